// File: rtl/fifo_axis_packetizer_pkg.sv
// ============================================================================
// Package : fifo_axis_packetizer_pkg
// State encodings and skid-entry sizing shared by the packetizer files.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_axis_packetizer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam int SKID_LAST_W = 1;

    // A skid entry carries {data, last}
    function automatic int skid_entry_width(input int data_w);
        return data_w + SKID_LAST_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_axis_packetizer_skid.sv
// ============================================================================
// Module  : axis_skid_buffer
// Two-entry registered skid; entry 0 is the output register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_skid_buffer
    import fifo_axis_packetizer_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             space,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             empty
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic             w_pop;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_ent0;
    assign empty     = (r_count == 2'd0);
    assign w_pop     = out_valid && out_ready;
    // A full buffer still accepts when the head leaves this cycle
    assign space     = (r_count < 2'd2) || w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else if (clr) begin
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else begin
            case ({w_pop, in_valid})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= in_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= in_data;
                    end
                end
                2'b10: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= in_data;
                    end else begin
                        r_ent1 <= in_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_axis_packetizer.sv
// ============================================================================
// Module  : fifo_axis_packetizer
// Drains a show-ahead FIFO into an AXI4-Stream master, TLAST every pkt_len beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_axis_packetizer
    import fifo_axis_packetizer_pkg::*;
#(
    parameter int P1WIDTH         = 32,
    parameter int P2LEN_WIDTH     = 16,
    parameter int P3PKT_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       enable,
    input  logic [P2LEN_WIDTH-1:0]     pkt_len,
    input  logic [P1WIDTH-1:0]         fifo_d,
    input  logic                       fifo_empty_n,
    output logic                       fifo_deq,
    output logic [P1WIDTH-1:0]         m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       pkt_done,
    output logic [P3PKT_CNT_WIDTH-1:0] pkt_count,
    output logic                       busy
);

    localparam int ENTRY_W = skid_entry_width(P1WIDTH);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [P2LEN_WIDTH-1:0]     r_beat_cnt;
    logic [P2LEN_WIDTH-1:0]     r_len_q;
    logic [P3PKT_CNT_WIDTH-1:0] r_pkt_count;
    logic                       r_pkt_done;

    logic [P2LEN_WIDTH-1:0]     w_len_eff;
    logic [P2LEN_WIDTH-1:0]     w_cur_len;
    logic [P2LEN_WIDTH-1:0]     w_beat_nxt;
    logic                       w_last;
    logic                       w_active;
    logic                       w_space;
    logic                       w_deq;
    logic                       w_skid_empty;
    logic                       w_tvalid;
    logic                       w_last_hs;
    logic [ENTRY_W-1:0]         w_entry_out;

    // The first beat of a packet uses the live length; later beats use the latched one
    assign w_len_eff  = (pkt_len == '0) ? P2LEN_WIDTH'(1) : pkt_len;
    assign w_cur_len  = (r_beat_cnt == '0) ? w_len_eff : r_len_q;
    assign w_last     = (r_beat_cnt == (w_cur_len - P2LEN_WIDTH'(1)));
    assign w_active   = (r_state == ST_RUN) || (r_state == ST_FINISH);
    assign w_deq      = fifo_empty_n && w_space && w_active && !clr;
    assign w_beat_nxt = !w_deq ? r_beat_cnt :
                        (w_last ? '0 : r_beat_cnt + P2LEN_WIDTH'(1));

    axis_skid_buffer #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (w_deq),
        .in_data   ({fifo_d, w_last}),
        .space     (w_space),
        .out_valid (w_tvalid),
        .out_data  (w_entry_out),
        .out_ready (m_axis_tready),
        .empty     (w_skid_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A beat dequeued this cycle may open a packet that must be completed
                if (!enable) w_state_nxt = (w_beat_nxt == '0) ? ST_IDLE : ST_FINISH;
            end
            ST_FINISH: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else if (w_deq && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            if (w_deq && (r_beat_cnt == '0)) r_len_q <= w_len_eff;
        end
    end

    assign w_last_hs = w_tvalid && m_axis_tready && w_entry_out[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_done  <= 1'b0;
            r_pkt_count <= '0;
        end else if (clr) begin
            r_pkt_done  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_pkt_done <= w_last_hs;
            if (w_last_hs) r_pkt_count <= r_pkt_count + P3PKT_CNT_WIDTH'(1);
        end
    end

    assign fifo_deq      = w_deq;
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_entry_out[ENTRY_W-1:1];
    assign m_axis_tlast  = w_entry_out[0] && w_tvalid;
    assign pkt_done      = r_pkt_done;
    assign pkt_count     = r_pkt_count;
    assign busy          = (r_state != ST_IDLE) || !w_skid_empty;

`ifndef SYNTHESIS
    a_deq_needs_data : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_deq |-> fifo_empty_n);
    a_stream_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (m_axis_tvalid && !m_axis_tready && !clr) |=>
        (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_axis_packetizer.sv
// ============================================================================
// Module  : tb_fifo_axis_packetizer
// Self-checking bench: FIFO model, stream scoreboard, vector table, corner sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_axis_packetizer;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        int          nwords;
        logic [3:0]  rdy;
        int          exp_pkts;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        enable;
    logic [15:0] pkt_len;
    logic [31:0] fifo_d;
    logic        fifo_empty_n;
    logic        fifo_deq;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        pkt_done;
    logic [31:0] pkt_count;
    logic        busy;

    logic [31:0] fq[$];
    logic [31:0] push_q[$];
    beat_t       exp_q[$];
    vec_t        vecs[5];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        flush;
    logic [3:0]  rdy_pat;
    int          rdy_idx;
    logic        deq_seen;
    int          deq_vec, done_vec, outstanding, cyc, first_deq, last_deq;
    logic        prev_deq, prev_stall, st_l;
    logic [31:0] st_d;

    always #5 clk = ~clk;

    fifo_axis_packetizer #(
        .P1WIDTH         (32),
        .P2LEN_WIDTH     (16),
        .P3PKT_CNT_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .enable        (enable),
        .pkt_len       (pkt_len),
        .fifo_d        (fifo_d),
        .fifo_empty_n  (fifo_empty_n),
        .fifo_deq      (fifo_deq),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .pkt_done      (pkt_done),
        .pkt_count     (pkt_count),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_it, input bit last);
        beat_t b;
        push_q.push_back(w);
        if (expect_it) begin
            b.d = w;
            b.l = last;
            exp_q.push_back(b);
        end
    endtask

    task automatic restart();
        @(posedge clk); #2;
        clr = 1'b1; flush = 1'b1; enable = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0; flush = 1'b0;
        exp_q.delete();
        @(posedge clk); #2;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_deqs(input int target, input int budget);
        int n = 0;
        while (deq_vec < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("deq_wait_timeout", 64'(deq_vec >= target), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int len_eff;
        restart();
        pkt_len = v.len;
        rdy_pat = v.rdy;
        len_eff = (v.len == 16'd0) ? 1 : int'(v.len);
        for (int i = 0; i < v.nwords; i++)
            push_word(32'(idx * 256 + i), 1'b1, (i % len_eff) == len_eff - 1);
        deq_vec = 0; done_vec = 0; first_deq = -1;
        @(posedge clk); #2;
        enable = 1'b1;
        wait_drain(300);
        repeat (3) @(posedge clk);
        #2 enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("vec_pkt_count", 64'(pkt_count), 64'(v.exp_pkts));
        chk("vec_pkt_done_pulses", 64'(done_vec), 64'(v.exp_pkts));
        chk("vec_busy_idle", 64'(busy), 64'd0);
        chk("vec_deq_total", 64'(deq_vec), 64'(v.nwords));
        if (v.rdy == 4'hF)
            chk("vec_full_rate_deq", 64'(last_deq - first_deq + 1), 64'(v.nwords));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; enable = 1'b0; pkt_len = 16'd4;
        flush = 1'b0; rdy_pat = 4'hF; rdy_idx = 0;
        fifo_d = '0; fifo_empty_n = 1'b0; tready = 1'b0;
        deq_seen = 1'b0; deq_vec = 0; done_vec = 0; outstanding = 0; cyc = 0;
        first_deq = -1; last_deq = 0; prev_deq = 1'b0; prev_stall = 1'b0;
        st_d = '0; st_l = 1'b0;

        vecs[0] = '{len: 16'd4, nwords: 8,  rdy: 4'hF,    exp_pkts: 2};
        vecs[1] = '{len: 16'd3, nwords: 6,  rdy: 4'b1001, exp_pkts: 2};
        vecs[2] = '{len: 16'd0, nwords: 3,  rdy: 4'hF,    exp_pkts: 3};
        vecs[3] = '{len: 16'd1, nwords: 4,  rdy: 4'b0110, exp_pkts: 4};
        vecs[4] = '{len: 16'd6, nwords: 12, rdy: 4'b1011, exp_pkts: 2};

        fork
            // FIFO model and ready driver, updated just after each rising edge
            forever begin
                @(posedge clk); #1;
                if (deq_seen && fq.size() > 0) void'(fq.pop_front());
                deq_seen = 1'b0;
                if (flush) fq.delete();
                while (push_q.size() > 0) fq.push_back(push_q.pop_front());
                fifo_empty_n = (fq.size() != 0);
                fifo_d = fifo_empty_n ? fq[0] : 32'd0;
                tready = rdy_pat[rdy_idx % 4];
                rdy_idx++;
            end
            // Stream monitor and scoreboard, sampled mid-cycle
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n || clr) begin
                    prev_deq = 1'b0; prev_stall = 1'b0; deq_seen = 1'b0; outstanding = 0;
                end else begin
                    if (prev_deq) chk("deq_to_tvalid_latency", 64'(tvalid), 64'd1);
                    if (prev_stall) begin
                        chk("stall_tvalid", 64'(tvalid), 64'd1);
                        chk("stall_tdata", 64'(tdata), 64'(st_d));
                        chk("stall_tlast", 64'(tlast), 64'(st_l));
                    end
                    if (fifo_deq) begin
                        deq_vec++;
                        outstanding++;
                        if (first_deq < 0) first_deq = cyc;
                        last_deq = cyc;
                    end
                    if (tvalid && tready) begin
                        beat_t e;
                        outstanding--;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", 64'(tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_tdata", 64'(tdata), 64'(e.d));
                            chk("beat_tlast", 64'(tlast), 64'(e.l));
                        end
                    end
                    if (fifo_deq) chk("deq_ahead_le2", 64'(outstanding <= 2), 64'd1);
                    if (pkt_done) done_vec++;
                    deq_seen   = fifo_deq;
                    prev_deq   = fifo_deq;
                    prev_stall = tvalid && !tready;
                    st_d       = tdata;
                    st_l       = tlast;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fifo_deq", 64'(fifo_deq), 64'd0);

        for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

        // ENABLE dropped mid-packet: the packet still completes, then idle
        restart();
        pkt_len = 16'd5; rdy_pat = 4'hF;
        for (int i = 0; i < 10; i++) push_word(32'h1000 + 32'(i), i < 5, i == 4);
        deq_vec = 0;
        @(posedge clk); #2 enable = 1'b1;
        wait_deqs(2, 50);
        @(posedge clk); #2 enable = 1'b0;
        wait_drain(100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("endrop_busy", 64'(busy), 64'd0);
        chk("endrop_fifo_left", 64'(fq.size()), 64'd5);
        chk("endrop_pkt_count", 64'(pkt_count), 64'd1);
        chk("endrop_deq_total", 64'(deq_vec), 64'd5);

        // CLR with two beats buffered mid-packet
        restart();
        pkt_len = 16'd2; rdy_pat = 4'hF;
        push_word(32'h2000, 1'b1, 1'b0);
        push_word(32'h2001, 1'b1, 1'b1);
        @(posedge clk); #2 enable = 1'b1;
        wait_drain(50);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("clr_pre_pkt_count", 64'(pkt_count), 64'd1);
        @(posedge clk); #2;
        rdy_pat = 4'h0; pkt_len = 16'd4; deq_vec = 0;
        for (int i = 0; i < 6; i++) push_word(32'h2100 + 32'(i), 1'b0, 1'b0);
        wait_deqs(2, 50);
        repeat (3) @(negedge clk);
        chk("clr_pre_tvalid", 64'(tvalid), 64'd1);
        chk("clr_pre_tdata", 64'(tdata), 64'h2100);
        chk("clr_pre_deq_stalled", 64'(deq_vec), 64'd2);
        @(posedge clk); #2 clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
        @(negedge clk);
        chk("clr_tvalid", 64'(tvalid), 64'd0);
        chk("clr_pkt_count", 64'(pkt_count), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_fifo_deq", 64'(fifo_deq), 64'd0);
        for (int i = 2; i < 6; i++) begin
            beat_t b;
            b.d = 32'h2100 + 32'(i);
            b.l = (i == 5);
            exp_q.push_back(b);
        end
        rdy_pat = 4'hF;
        wait_drain(100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("clr_post_pkt_count", 64'(pkt_count), 64'd1);
        chk("clr_post_fifo_left", 64'(fq.size()), 64'd0);

        // Asynchronous reset pulse while streaming
        restart();
        pkt_len = 16'd3; rdy_pat = 4'hF; deq_vec = 0;
        for (int i = 0; i < 9; i++) push_word(32'h3000 + 32'(i), 1'b1, (i % 3) == 2);
        @(posedge clk); #2 enable = 1'b1;
        wait_deqs(4, 50);
        @(posedge clk); #2;
        chk("arst_pre_tvalid", 64'(tvalid), 64'd1);
        chk("arst_pre_fifo_deq", 64'(fifo_deq), 64'd1);
        #1 rst_n = 1'b0; enable = 1'b0;
        #1;
        chk("arst_tvalid", 64'(tvalid), 64'd0);
        chk("arst_fifo_deq", 64'(fifo_deq), 64'd0);
        chk("arst_tlast", 64'(tlast), 64'd0);
        chk("arst_tdata", 64'(tdata), 64'd0);
        chk("arst_pkt_done", 64'(pkt_done), 64'd0);
        chk("arst_pkt_count", 64'(pkt_count), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        restart();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
